// File: rtl/compfree_sort_if.sv
// Load/stream bundle for the comparison-free sort sequencer.
// The sorter sits on the slave side; the loader/consumer sits on the master side.
interface compfree_sort_if #(
    parameter int unsigned ELEMENT_NUM = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned IDX_W       = 3
);
    logic                              load;
    logic                              descend;
    logic [ELEMENT_NUM*DATA_WIDTH-1:0] data_in;
    logic                              busy;
    logic                              out_valid;
    logic                              out_ready;
    logic [IDX_W-1:0]                  out_idx;
    logic [DATA_WIDTH-1:0]             out_data;
    logic                              out_last;
    logic                              done;

    modport master (
        output load, descend, data_in, out_ready,
        input  busy, out_valid, out_idx, out_data, out_last, done
    );

    modport slave (
        input  load, descend, data_in, out_ready,
        output busy, out_valid, out_idx, out_data, out_last, done
    );
endinterface

// File: rtl/compfree_sort_ctrl.sv
// Bit-serial comparison-free sort sequencer: scans bit-planes MSB->LSB to find the
// current extreme set, emits it one index per handshake, then rescans what remains.
module compfree_sort_ctrl #(
    parameter int unsigned ELEMENT_NUM = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned IDX_W       = 3
) (
    input logic             clk,
    input logic             rst_n,
    compfree_sort_if.slave  bus
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [1:0]                        state_q;
    logic [ELEMENT_NUM*DATA_WIDTH-1:0] data_q;
    logic                              descend_q;
    logic [ELEMENT_NUM-1:0]            remaining_q;
    logic [ELEMENT_NUM-1:0]            evt_q;
    logic [ELEMENT_NUM-1:0]            winner_q;
    logic [CNT_W-1:0]                  bit_cnt_q;
    logic                              done_q;

    logic [ELEMENT_NUM-1:0] plane;
    logic [ELEMENT_NUM-1:0] blk_data;
    logic [ELEMENT_NUM-1:0] cand;
    logic [ELEMENT_NUM-1:0] nxt_evt;
    logic [ELEMENT_NUM-1:0] sel_onehot;
    logic [ELEMENT_NUM-1:0] winner_nxt;
    logic [ELEMENT_NUM-1:0] remaining_nxt;
    logic [IDX_W-1:0]       sel_idx;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [DATA_WIDTH-1:0]  elem;
    logic                   rem_single;
    logic                   fire;

    // Block: keep candidates holding the wanted bit; if none hold it, keep them all.
    always_comb begin
        plane = '0;
        elem  = '0;
        for (int i = 0; i < int'(ELEMENT_NUM); i++) begin
            elem     = data_q[i*DATA_WIDTH +: DATA_WIDTH];
            plane[i] = elem[bit_cnt_q];
        end
        blk_data = descend_q ? plane : ~plane;
        cand     = evt_q & blk_data;
        nxt_evt  = (cand != '0) ? cand : evt_q;
    end

    // Lowest set winner bit gives stable ordering among equal values.
    always_comb begin
        sel_idx    = '0;
        sel_data   = '0;
        sel_onehot = '0;
        for (int i = int'(ELEMENT_NUM) - 1; i >= 0; i--) begin
            if (winner_q[i]) begin
                sel_idx       = IDX_W'(i);
                sel_data      = data_q[i*DATA_WIDTH +: DATA_WIDTH];
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        fire          = (state_q == EMIT) && bus.out_ready;
        winner_nxt    = winner_q & ~sel_onehot;
        remaining_nxt = remaining_q & ~sel_onehot;
        rem_single    = (remaining_q != '0) &&
                        ((remaining_q & (remaining_q - ELEMENT_NUM'(1))) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            descend_q   <= 1'b0;
            remaining_q <= '0;
            evt_q       <= '0;
            winner_q    <= '0;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        data_q      <= bus.data_in;
                        descend_q   <= bus.descend;
                        remaining_q <= '1;
                        evt_q       <= '1;
                        bit_cnt_q   <= CNT_MAX;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    evt_q <= nxt_evt;
                    if (bit_cnt_q == '0) begin
                        winner_q <= nxt_evt;
                        state_q  <= EMIT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    end
                end
                EMIT: begin
                    if (fire) begin
                        winner_q    <= winner_nxt;
                        remaining_q <= remaining_nxt;
                        if (winner_nxt == '0) begin
                            if (remaining_nxt != '0) begin
                                evt_q     <= remaining_nxt;
                                bit_cnt_q <= CNT_MAX;
                                state_q   <= SCAN;
                            end else begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.out_valid = (state_q == EMIT);
        bus.out_idx   = (state_q == EMIT) ? sel_idx : '0;
        bus.out_data  = (state_q == EMIT) ? sel_data : '0;
        bus.out_last  = (state_q == EMIT) && rem_single;
        bus.done      = done_q;
    end
endmodule

// File: tb/tb_compfree_sort_ctrl.sv
// Directed bench for compfree_sort_ctrl with 4 elements of 4 bits.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_compfree_sort_ctrl;
    int n_checks = 0;
    int n_fail   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    compfree_sort_if #(.ELEMENT_NUM(4), .DATA_WIDTH(4), .IDX_W(2)) bus ();

    compfree_sort_ctrl #(.ELEMENT_NUM(4), .DATA_WIDTH(4), .IDX_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic       tr_valid[0:63];
    logic [1:0] tr_idx[0:63];
    logic [3:0] tr_data[0:63];
    int         hs_idx[0:7];
    int         hs_data[0:7];
    int         hs_last[0:7];
    int         hs_n, done_n, done_cyc, first_valid;

    // Present a load for one cycle; returns on the falling edge after it was taken.
    task automatic do_load(input logic [15:0] d, input logic desc);
        @(negedge clk);
        bus.load    = 1'b1;
        bus.descend = desc;
        bus.data_in = d;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Monitor ncyc cycles; stalls out_ready for 3 cycles from stall_start and
    // pulses a conflicting load at busy_load_cyc.
    task automatic collect(input int ncyc, input int stall_start, input int busy_load_cyc);
        hs_n = 0; done_n = 0; done_cyc = -1; first_valid = -1;
        for (int i = 0; i < 8; i++) begin
            hs_idx[i] = -1; hs_data[i] = -1; hs_last[i] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            bus.out_ready = !(c >= stall_start && c < stall_start + 3);
            bus.load      = (c == busy_load_cyc);
            if (c == busy_load_cyc) begin
                bus.data_in = 16'h0F0F;
                bus.descend = 1'b1;
            end
            tr_valid[c] = bus.out_valid;
            tr_idx[c]   = bus.out_idx;
            tr_data[c]  = bus.out_data;
            if (bus.out_valid && first_valid < 0) first_valid = c;
            if (bus.out_valid && bus.out_ready && hs_n < 8) begin
                hs_idx[hs_n]  = int'(bus.out_idx);
                hs_data[hs_n] = int'(bus.out_data);
                hs_last[hs_n] = int'(bus.out_last);
                hs_n++;
            end
            if (bus.done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.load      = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({bus.busy, bus.out_valid, bus.out_last, bus.done, bus.out_idx, bus.out_data} !== 10'd0) begin
            $display("FAIL reset_outputs: got %b required 0", {bus.busy, bus.out_valid,
                     bus.out_last, bus.done, bus.out_idx, bus.out_data});
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.out_valid, bus.done} !== 3'd0) begin
            $display("FAIL idle_after_reset: got %b required 000", {bus.busy, bus.out_valid, bus.done});
            n_fail++;
        end
    endtask

    task automatic test_ascending;
        int exp_i[4] = '{1, 3, 2, 0};
        int exp_d[4] = '{1, 1, 2, 3};
        do_load(16'h1213, 1'b0);
        collect(24, 1000, -1);
        n_checks++;
        if (first_valid !== 4) begin
            $display("FAIL asc_latency: got %0d required 4", first_valid); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (hs_idx[i] !== exp_i[i] || hs_data[i] !== exp_d[i] || hs_last[i] !== int'(i == 3)) begin
                $display("FAIL asc_elem%0d: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                         i, hs_idx[i], hs_data[i], hs_last[i], exp_i[i], exp_d[i], int'(i == 3));
                n_fail++;
            end
        end
        n_checks++;
        if (done_n !== 1 || done_cyc !== 16) begin
            $display("FAIL asc_done: got count=%0d cyc=%0d required count=1 cyc=16", done_n, done_cyc);
            n_fail++;
        end
    endtask

    task automatic test_descending;
        int exp_i[4] = '{0, 2, 1, 3};
        int exp_d[4] = '{3, 2, 1, 1};
        do_load(16'h1213, 1'b1);
        collect(24, 1000, -1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (hs_idx[i] !== exp_i[i] || hs_data[i] !== exp_d[i] || hs_last[i] !== int'(i == 3)) begin
                $display("FAIL desc_elem%0d: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                         i, hs_idx[i], hs_data[i], hs_last[i], exp_i[i], exp_d[i], int'(i == 3));
                n_fail++;
            end
        end
        n_checks++;
        if (done_n !== 1 || done_cyc !== 16) begin
            $display("FAIL desc_done: got count=%0d cyc=%0d required count=1 cyc=16", done_n, done_cyc);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        do_load(16'h5555, 1'b0);
        collect(16, 1000, -1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (hs_idx[i] !== i || hs_data[i] !== 5 || hs_last[i] !== int'(i == 3)) begin
                $display("FAIL equal_elem%0d: got (%0d,%0d,last=%0d) required (%0d,5,last=%0d)",
                         i, hs_idx[i], hs_data[i], hs_last[i], i, int'(i == 3));
                n_fail++;
            end
        end
        n_checks++;
        if (first_valid !== 4 || done_n !== 1 || done_cyc !== 8) begin
            $display("FAIL equal_timing: got valid@%0d done=%0d@%0d required valid@4 done=1@8",
                     first_valid, done_n, done_cyc);
            n_fail++;
        end
    endtask

    task automatic test_backpressure;
        int exp_i[4] = '{1, 3, 2, 0};
        int exp_d[4] = '{1, 1, 2, 3};
        do_load(16'h1213, 1'b0);
        collect(28, 4, -1);
        for (int c = 4; c < 7; c++) begin
            n_checks++;
            if (tr_valid[c] !== 1'b1 || tr_idx[c] !== 2'd1 || tr_data[c] !== 4'd1) begin
                $display("FAIL bp_hold_c%0d: got (v=%b,%0d,%0d) required (v=1,1,1)",
                         c, tr_valid[c], tr_idx[c], tr_data[c]);
                n_fail++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (hs_idx[i] !== exp_i[i] || hs_data[i] !== exp_d[i]) begin
                $display("FAIL bp_elem%0d: got (%0d,%0d) required (%0d,%0d)",
                         i, hs_idx[i], hs_data[i], exp_i[i], exp_d[i]);
                n_fail++;
            end
        end
        n_checks++;
        if (done_n !== 1 || done_cyc !== 19) begin
            $display("FAIL bp_done: got count=%0d cyc=%0d required count=1 cyc=19", done_n, done_cyc);
            n_fail++;
        end
    endtask

    task automatic test_load_while_busy;
        int exp_i[4] = '{1, 3, 2, 0};
        int exp_d[4] = '{1, 1, 2, 3};
        do_load(16'h1213, 1'b0);
        collect(24, 1000, 2);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (hs_idx[i] !== exp_i[i] || hs_data[i] !== exp_d[i]) begin
                $display("FAIL busy_load_elem%0d: got (%0d,%0d) required (%0d,%0d)",
                         i, hs_idx[i], hs_data[i], exp_i[i], exp_d[i]);
                n_fail++;
            end
        end
        n_checks++;
        if (hs_n !== 4 || done_n !== 1 || done_cyc !== 16) begin
            $display("FAIL busy_load_done: got hs=%0d done=%0d@%0d required hs=4 done=1@16",
                     hs_n, done_n, done_cyc);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        do_load(16'h1213, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.out_valid, bus.out_last, bus.done, bus.out_idx, bus.out_data} !== 10'd0) begin
            $display("FAIL rst_mid_scan: got %b required 0", {bus.busy, bus.out_valid,
                     bus.out_last, bus.done, bus.out_idx, bus.out_data});
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        do_load(16'h5555, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd5) begin
            $display("FAIL rst_pre_emit: got (v=%b,%0d) required (v=1,5)", bus.out_valid, bus.out_data);
            n_fail++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.out_valid, bus.out_last, bus.done, bus.out_idx, bus.out_data} !== 10'd0) begin
            $display("FAIL rst_mid_emit: got %b required 0", {bus.busy, bus.out_valid,
                     bus.out_last, bus.done, bus.out_idx, bus.out_data});
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            $display("FAIL rst_no_done: got %0d active cycles required 0", seen_done);
            n_fail++;
        end
    endtask

    task automatic test_extremes;
        int exp_i[4] = '{1, 3, 0, 2};
        int exp_d[4] = '{0, 0, 15, 15};
        do_load(16'h0F0F, 1'b0);
        collect(20, 1000, -1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (hs_idx[i] !== exp_i[i] || hs_data[i] !== exp_d[i] || hs_last[i] !== int'(i == 3)) begin
                $display("FAIL ext_elem%0d: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                         i, hs_idx[i], hs_data[i], hs_last[i], exp_i[i], exp_d[i], int'(i == 3));
                n_fail++;
            end
        end
        n_checks++;
        if (done_n !== 1 || done_cyc !== 12) begin
            $display("FAIL ext_done: got count=%0d cyc=%0d required count=1 cyc=12", done_n, done_cyc);
            n_fail++;
        end
    endtask

    initial begin
        bus.load      = 1'b0;
        bus.descend   = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_ascending();
        test_descending();
        test_back_to_back();
        test_backpressure();
        test_load_while_busy();
        test_reset_mid();
        test_extremes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/compfree_sort_ctrl.md
Name: compfree_sort_ctrl

Overview:
- Bit-serial sequencer for the comparison-free sorter.
- Loads a set of ELEMENT_NUM values and time-multiplexes one Block instance (Data, prev_evt, nxt_evt) over the bit-planes, MSB to LSB. After a scan, the surviving event vector marks every element holding the current extreme value.
- Emits those elements one per handshake, retires them, and rescans until all elements are emitted.
- Feeds downstream consumers a stable sorted stream of (index, value).

Parameters:
ELEMENT_NUM, 8, number of elements per sort; must match the Block width
DATA_WIDTH, 8, bits per element
IDX_W, 3, index width, equal to clog2(ELEMENT_NUM), minimum 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  start a sort; sampled only when busy=0
descend  input  1  0 = ascending, 1 = descending; latched on accepted load
data_in  input  ELEMENT_NUM*DATA_WIDTH  element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
busy  output  1  high in SCAN or EMIT
out_valid  output  1  sorted element available
out_ready  input  1  consumer accepts the element
out_idx  output  IDX_W  original index of the emitted element
out_data  output  DATA_WIDTH  value of the emitted element
out_last  output  1  emitted element is the final one of the sort
done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; remaining, evt, winner and bit counter cleared.
  - busy, out_valid, out_last and done are 0; out_idx and out_data are 0.
- States: IDLE, SCAN, EMIT.
- IDLE:
  - On load=1, register data_in and descend.
  - Set remaining to all ones and evt to all ones; set bit_cnt to DATA_WIDTH-1; go to SCAN next cycle.
  - load while busy=1 is ignored and has no effect.
- SCAN, one bit-plane per cycle:
  - plane[i] = element[i][bit_cnt].
  - Block Data = ~plane when ascending; Data = plane when descending.
  - prev_evt = evt, and evt <= nxt_evt. The Block keeps prev_evt when no candidate has the bit, so evt never becomes zero while remaining is nonzero.
  - At bit_cnt=0: winner <= nxt_evt, go to EMIT. Otherwise bit_cnt decrements.
  - Each scan takes exactly DATA_WIDTH cycles.
- EMIT:
  - out_valid=1. out_idx = lowest set bit of winner; out_data = that element's value.
  - out_last = 1 when remaining has exactly one bit set.
  - Outputs are held stable while out_ready=0.
  - On out_valid & out_ready, clear that bit in winner and in remaining.
- After the handshake:
  - Winner still nonzero: stay in EMIT and present the next index the following cycle, with no bubble.
  - Winner empty and remaining nonzero: evt <= remaining, bit_cnt <= DATA_WIDTH-1, go to SCAN.
  - Winner empty and remaining zero: go to IDLE and pulse done for one cycle, the cycle after the last handshake.
- Duplicate values: all equal extremes come out in one scan, in ascending original index (stable sort).
- Latency:
  - First out_valid arrives DATA_WIDTH+1 cycles after the load cycle.
  - Total time is DATA_WIDTH x (distinct values) + ELEMENT_NUM handshake cycles at out_ready=1.
- Reset mid-operation aborts immediately. No partial output and no done pulse.
- Element value all-zeros or all-ones needs no special handling. ELEMENT_NUM=1 gives one scan and one emit with out_last=1.

Test Plan:
- ELEMENT_NUM=4, DATA_WIDTH=4, ascending, data {3,1,2,1} for idx0..3, out_ready=1:
  - Stream is (1,1),(3,1),(2,2),(0,3), with out_last only on (0,3).
  - done pulses once; 3 scans of 4 cycles each.
- Same data, descend=1 -> stream (0,3),(2,2),(1,1),(3,1).
- All elements equal to 5, ascending -> a single scan, then idx0..3 back to back. Total 4 scan cycles + 4 emit cycles.
- Backpressure: out_ready low for 3 cycles during EMIT -> out_idx, out_data and out_valid hold, and the stream order is unchanged.
- load pulse while busy -> ignored, and the current sort completes with its original data. rst_n low mid-SCAN -> all outputs 0 asynchronously; a new load then sorts correctly.
- Data {15,0,15,0}, ascending -> (1,0),(3,0),(0,15),(2,15). Checks the all-ones and all-zeros extremes.
